// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath widths, the canonical NOP,
// and the fetch-stage state encoding.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned IFID_W = 64;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH,
    DROP
  } if_state_t;

  // IF/ID bubble carrying a given pc tag
  function automatic logic [IFID_W-1:0] ifid_bubble(input logic [XLEN-1:0] pc);
    return {pc, NOP_INSTR};
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register for an instruction word that came back from the
// icache while decode was stalled. load takes priority over clear so the entry
// can be drained and refilled in the same cycle.
import riscv_pkg::*;

module if_skid_buffer (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            load,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_data,
  output logic            buf_valid,
  output logic [XLEN-1:0] buf_pc,
  output logic [XLEN-1:0] buf_data
);

  // Capture, hold or drop the single buffered word
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_data  <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_pc    <= in_pc;
      buf_data  <= in_data;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the icache request and fills
// the IF/ID register. Handles stalls, EX redirects and multi-cycle misses,
// including a redirect that lands while a miss is outstanding (DROP state).
// Optional feature: define IF_SKID_EN to keep a word returned during a stall.
import riscv_pkg::*;

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] target_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_ready_i,
  output logic [63:0] if_out,
  output logic        if_valid_o,
  output logic        fetch_busy_o
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic [31:0] next_addr;

  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_data;

  assign next_addr    = fetch_addr + PC_STEP;
  // Request is live in every non-reset cycle; reset abandons any pending miss
  assign imem_req_o   = ~reset;
  assign imem_addr_o  = fetch_addr;
  assign fetch_busy_o = ~reset & ((state == DROP) | ~imem_ready_i);

`ifdef IF_SKID_EN
  logic skid_load;
  logic skid_clear;

  // Capture during a stall if empty; refill while draining so hits keep streaming
  always_comb begin
    skid_load  = 1'b0;
    skid_clear = flush_i;
    if (state == FETCH && !flush_i) begin
      skid_load = imem_ready_i & (stall_i ? ~skid_valid : skid_valid);
      if (!stall_i && skid_valid) skid_clear = 1'b1;
    end
  end

  if_skid_buffer u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (skid_clear),
    .load      (skid_load),
    .in_pc     (fetch_addr),
    .in_data   (imem_rdata_i),
    .buf_valid (skid_valid),
    .buf_pc    (skid_pc),
    .buf_data  (skid_data)
  );
`else
  assign skid_valid = 1'b0;
  assign skid_pc    = '0;
  assign skid_data  = '0;
`endif

  // Fetch FSM: PC/fetch-address update and registered IF/ID outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      if_out     <= ifid_bubble('0);
      if_valid_o <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (flush_i) begin
            pc         <= target_pc_i;
            if_out     <= ifid_bubble('0);
            if_valid_o <= 1'b0;
            if (imem_ready_i) fetch_addr <= target_pc_i;
            else              state      <= DROP;
          end else if (stall_i) begin
`ifdef IF_SKID_EN
            if (skid_load) begin
              pc         <= next_addr;
              fetch_addr <= next_addr;
            end
`endif
          end else if (skid_valid) begin
            // Buffered word goes first; a same-cycle return refills the buffer
            if_out     <= {skid_pc, skid_data};
            if_valid_o <= 1'b1;
            if (imem_ready_i) begin
              pc         <= next_addr;
              fetch_addr <= next_addr;
            end
          end else if (imem_ready_i) begin
            if_out     <= {fetch_addr, imem_rdata_i};
            if_valid_o <= 1'b1;
            pc         <= next_addr;
            fetch_addr <= next_addr;
          end else begin
            if_out     <= ifid_bubble(fetch_addr);
            if_valid_o <= 1'b0;
          end
        end
        DROP: begin
          // Stale request stays on the bus until the icache completes it
          if_valid_o <= 1'b0;
          if (flush_i) pc <= target_pc_i;
          if (imem_ready_i) begin
            fetch_addr <= flush_i ? target_pc_i : pc;
            state      <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: cycle table of stimulus and expected bus/output
// values, expected IF/ID contents queued at drive time and popped after the edge.
module tb_if_fetch_stage;

`ifdef IF_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, flush_i, imem_ready_i;
  logic [31:0] target_pc_i, imem_rdata_i;
  logic        imem_req_o, if_valid_o, fetch_busy_o;
  logic [31:0] imem_addr_o;
  logic [63:0] if_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          stall, flush, ready;
    logic [31:0] target;
    logic [31:0] exp_addr;
    bit          exp_busy, exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb[$];

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .target_pc_i  (target_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .imem_ready_i (imem_ready_i),
    .if_out       (if_out),
    .if_valid_o   (if_valid_o),
    .fetch_busy_o (fetch_busy_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(bit st, bit fl, logic [31:0] tg, bit rd,
                             logic [31:0] ea, bit eb, bit ev, logic [31:0] ep);
    vec_t r;
    r.stall = st; r.flush = fl; r.target = tg; r.ready = rd;
    r.exp_addr = ea; r.exp_busy = eb; r.exp_valid = ev; r.exp_pc = ep;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check bus before the edge, check IF/ID after it
  task automatic run_cycle(input vec_t r, input int idx);
    logic [63:0] exp_out;
    stall_i      = r.stall;
    flush_i      = r.flush;
    target_pc_i  = r.target;
    imem_ready_i = r.ready;
    #1;
    imem_rdata_i = imem_addr_o ^ KEY;
    #2;
    check($sformatf("addr[%0d]", idx), {32'd0, imem_addr_o}, {32'd0, r.exp_addr});
    check($sformatf("req[%0d]", idx), {63'd0, imem_req_o}, 64'd1);
    check($sformatf("busy[%0d]", idx), {63'd0, fetch_busy_o}, {63'd0, r.exp_busy});
    sb.push_back(r.exp_valid ? {r.exp_pc, r.exp_pc ^ KEY} : {r.exp_pc, NOP});
    @(posedge clk);
    #1;
    check($sformatf("valid[%0d]", idx), {63'd0, if_valid_o}, {63'd0, r.exp_valid});
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty[%0d]: got %h expected queued entry", idx, if_out);
    end else begin
      exp_out = sb.pop_front();
      check($sformatf("if_out[%0d]", idx), if_out, exp_out);
    end
  endtask

  initial begin
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0; target_pc_i = '0;
    imem_ready_i = 1'b1; imem_rdata_i = '0;

    // sequential hits, miss at 8, hit-path flush, mid-miss flush
    vecs.push_back(v(0,0,32'h0,1,          32'h0,0,1,32'h0));
    vecs.push_back(v(0,0,32'h0,1,          32'h4,0,1,32'h4));
    vecs.push_back(v(0,0,32'h0,0,          32'h8,1,0,32'h8));
    vecs.push_back(v(0,0,32'h0,0,          32'h8,1,0,32'h8));
    vecs.push_back(v(0,0,32'h0,0,          32'h8,1,0,32'h8));
    vecs.push_back(v(0,0,32'h0,1,          32'h8,0,1,32'h8));
    vecs.push_back(v(0,0,32'h0,1,          32'hC,0,1,32'hC));
    vecs.push_back(v(0,1,32'h100,1,        32'h10,0,0,32'h0));
    vecs.push_back(v(0,0,32'h0,1,          32'h100,0,1,32'h100));
    vecs.push_back(v(0,0,32'h0,1,          32'h104,0,1,32'h104));
    vecs.push_back(v(0,1,32'h20,1,         32'h108,0,0,32'h0));
    vecs.push_back(v(0,1,32'h200,0,        32'h20,1,0,32'h0));
    vecs.push_back(v(0,0,32'h0,0,          32'h20,1,0,32'h0));
    vecs.push_back(v(0,0,32'h0,0,          32'h20,1,0,32'h0));
    vecs.push_back(v(0,0,32'h0,1,          32'h20,1,0,32'h0));
    vecs.push_back(v(0,0,32'h0,1,          32'h200,0,1,32'h200));
    // stall then stall+flush: flush wins
    vecs.push_back(v(1,0,32'h0,1,          32'h204,0,1,32'h200));
    vecs.push_back(v(1,1,32'h300,1,        SKID ? 32'h208 : 32'h204,0,0,32'h0));
    vecs.push_back(v(0,0,32'h0,1,          32'h300,0,1,32'h300));
    vecs.push_back(v(0,0,32'h0,1,          32'h304,0,1,32'h304));
    // PC wrap
    vecs.push_back(v(0,1,32'hFFFF_FFF8,1,  32'h308,0,0,32'h0));
    vecs.push_back(v(0,0,32'h0,1,          32'hFFFF_FFF8,0,1,32'hFFFF_FFF8));
    vecs.push_back(v(0,0,32'h0,1,          32'hFFFF_FFFC,0,1,32'hFFFF_FFFC));
    vecs.push_back(v(0,0,32'h0,1,          32'h0,0,1,32'h0));
    // 2-cycle stall with hits returning: discard/refetch, or skid capture
    vecs.push_back(v(1,0,32'h0,1,          32'h4,0,1,32'h0));
    vecs.push_back(v(1,0,32'h0,1,          SKID ? 32'h8 : 32'h4,0,1,32'h0));
    vecs.push_back(v(0,0,32'h0,1,          SKID ? 32'h8 : 32'h4,0,1,32'h4));
    vecs.push_back(v(0,0,32'h0,1,          SKID ? 32'hC : 32'h8,0,1,32'h8));
    vecs.push_back(v(0,0,32'h0,1,          SKID ? 32'h10 : 32'hC,0,1,32'hC));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {63'd0, imem_req_o}, 64'd0);
    check("rst_valid", {63'd0, if_valid_o}, 64'd0);
    check("rst_if_out", if_out, {32'd0, NOP});
    reset = 1'b0;

    foreach (vecs[i]) run_cycle(vecs[i], i);

    // reset in the middle of a miss abandons it and restarts at RESET_PC
    stall_i = 1'b0; flush_i = 1'b0; imem_ready_i = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check("mid_rst_req", {63'd0, imem_req_o}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_valid", {63'd0, if_valid_o}, 64'd0);
    check("mid_rst_if_out", if_out, {32'd0, NOP});
    #2;
    check("mid_rst_addr", {32'd0, imem_addr_o}, 64'd0);
    check("mid_rst_busy", {63'd0, fetch_busy_o}, 64'd1);
    imem_ready_i = 1'b1;
    imem_rdata_i = imem_addr_o ^ KEY;
    @(posedge clk);
    #1;
    check("post_rst_valid", {63'd0, if_valid_o}, 64'd1);
    check("post_rst_if_out", if_out, {32'd0, 32'd0 ^ KEY});

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
